// File: rtl/shift_seq_ctrl_pkg.sv
// Shared encodings and helpers for the multi-cycle shift sequencer.
package shift_pkg;

    localparam logic [2:0] SH_PASS = 3'b000;
    localparam logic [2:0] SH_LSR  = 3'b001;
    localparam logic [2:0] SH_LSL  = 3'b010;
    localparam logic [2:0] SH_ROR  = 3'b011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Total distance actually applied: shifts saturate at n, rotates wrap mod n.
    function automatic logic [5:0] eff_amount(input logic [4:0] amt,
                                              input logic [2:0] op,
                                              input int unsigned n);
        logic [31:0] a32;
        a32 = 32'(amt);
        case (op)
            SH_LSR, SH_LSL: return (a32 >= n) ? 6'(n) : 6'(a32);
            SH_ROR:         return 6'(a32 % n);
            default:        return '0;
        endcase
    endfunction

endpackage

// File: rtl/shift_seq_ctrl_if.sv
// Request/response handshake bundle between execute control and the shift sequencer.
interface shift_seq_ctrl_if #(
    parameter int N = 32
);
    logic         i_valid;
    logic         o_ready;
    logic [N-1:0] i_s2;
    logic [4:0]   i_shiftbit;
    logic [2:0]   i_srcon;
    logic         i_abort;
    logic         o_valid;
    logic         i_ready;
    logic [N-1:0] o_out;
    logic         o_busy;

    modport master (
        output i_valid, i_s2, i_shiftbit, i_srcon, i_abort, i_ready,
        input  o_ready, o_valid, o_out, o_busy
    );

    modport slave (
        input  i_valid, i_s2, i_shiftbit, i_srcon, i_abort, i_ready,
        output o_ready, o_valid, o_out, o_busy
    );
endinterface

// File: rtl/shift_seq_ctrl_step.sv
// Combinational single-step shifter: moves acc by k bits according to op.
module shift_step
    import shift_pkg::*;
#(
    parameter int N = 32
) (
    input  logic [N-1:0] acc,
    input  logic [4:0]   k,
    input  logic [2:0]   op,
    output logic [N-1:0] result
);

    logic [2*N-1:0] rot;

    always_comb begin
        // Rotate right falls out of the low half of the doubled word.
        rot = {acc, acc} >> k;
        case (op)
            SH_LSR:  result = acc >> k;
            SH_LSL:  result = acc << k;
            SH_ROR:  result = rot[N-1:0];
            default: result = acc;
        endcase
    end

endmodule

// File: rtl/shift_seq_ctrl.sv
// Shift/rotate sequencer: accepts one op, applies it STEP bits per cycle, returns result.
module shift_seq_ctrl #(
    parameter int N    = 32,
    parameter int STEP = 8
) (
    input  logic           i_clk,
    input  logic           i_rst,
    shift_seq_ctrl_if.slave bus
);
    import shift_pkg::*;

    localparam logic [5:0] STEP_W = 6'(STEP);

    state_t       state_q, state_d;
    logic [N-1:0] acc_q, acc_d;
    logic [5:0]   rem_q, rem_d;
    logic [2:0]   op_q, op_d;
    logic [4:0]   k;
    logic [N-1:0] step_out;

    shift_step #(.N(N)) u_step (
        .acc    (acc_q),
        .k      (k),
        .op     (op_q),
        .result (step_out)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            rem_q   <= '0;
            op_q    <= SH_PASS;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            rem_q   <= rem_d;
            op_q    <= op_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (!bus.i_abort && bus.i_valid) state_d = ST_RUN;
            ST_RUN: begin
                if (bus.i_abort)          state_d = ST_IDLE;
                else if (rem_q <= STEP_W) state_d = ST_DONE;
            end
            ST_DONE: if (bus.i_abort || bus.i_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        acc_d = acc_q;
        rem_d = rem_q;
        op_d  = op_q;
        k     = (rem_q < STEP_W) ? rem_q[4:0] : STEP_W[4:0];
        if (state_q == ST_IDLE && bus.i_valid && !bus.i_abort) begin
            acc_d = bus.i_s2;
            op_d  = bus.i_srcon;
            rem_d = eff_amount(bus.i_shiftbit, bus.i_srcon, N);
        end else if (state_q == ST_RUN && !bus.i_abort) begin
            acc_d = step_out;
            rem_d = rem_q - {1'b0, k};
        end
    end

    always_comb begin
        bus.o_ready = (state_q == ST_IDLE);
        bus.o_busy  = (state_q != ST_IDLE);
        bus.o_valid = (state_q == ST_DONE);
        bus.o_out   = (state_q == ST_DONE) ? acc_q : '0;
    end

endmodule
